// File: rtl/rf_wport_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wport_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// writeback (highest priority, never stalled) and the multi-cycle MUL/DIV
// unit. MUL/DIV results wait in a small FIFO until the pipeline leaves the
// port idle. A scoreboard tracks destination registers that still owe a
// MUL/DIV result so the ID stage can stall readers of those registers.
//
// Ports:
//   clk_i, rst_ni           clock (rising edge) / asynchronous active-low reset
//   wb_we_i/addr_i/data_i   pipeline writeback request
//   md_valid_i/addr_i/data_i, md_ready_o
//                           MUL/DIV result handshake into the FIFO
//   iss_valid_i, iss_rd_i   MUL/DIV issue; marks iss_rd_i pending
//   rs1_addr_i, rs2_addr_i  ID-stage source registers
//   rs1_pend_o, rs2_pend_o  source still awaits a MUL/DIV write
//   pend_mask_o             full scoreboard (bit 0 always 0)
//   rf_we_o/waddr_o/wd_o    registered register-file write port
//   buf_count_o             FIFO occupancy
// -----------------------------------------------------------------------------
module rf_wport_arbiter #(
    parameter int XLEN      = 32,
    parameter int AW        = 5,
    parameter int BUF_DEPTH = 2,
    localparam int CW       = $clog2(BUF_DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wb_we_i,
    input  logic [AW-1:0]     wb_addr_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic              md_valid_i,
    input  logic [AW-1:0]     md_addr_i,
    input  logic [XLEN-1:0]   md_data_i,
    output logic              md_ready_o,
    input  logic              iss_valid_i,
    input  logic [AW-1:0]     iss_rd_i,
    input  logic [AW-1:0]     rs1_addr_i,
    input  logic [AW-1:0]     rs2_addr_i,
    output logic              rs1_pend_o,
    output logic              rs2_pend_o,
    output logic [2**AW-1:0]  pend_mask_o,
    output logic              rf_we_o,
    output logic [AW-1:0]     rf_waddr_o,
    output logic [XLEN-1:0]   rf_wd_o,
    output logic [CW-1:0]     buf_count_o
);

    localparam int NREG = 2**AW;
    localparam int PW   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t            bufMem_q [BUF_DEPTH];
    logic [PW-1:0]     rdPtr_q, rdPtr_d;
    logic [PW-1:0]     wrPtr_q, wrPtr_d;
    logic [CW-1:0]     count_q, count_d;

    logic              rfWe_q, rfWe_d;
    logic [AW-1:0]     rfWaddr_q, rfWaddr_d;
    logic [XLEN-1:0]   rfWd_q, rfWd_d;
    logic              fromBuf_q, fromBuf_d;

    logic [NREG-1:0]   pendMask_q, pendMask_d;

    logic              mdReady;
    logic              push;
    logic              pop;
    logic              wbSel;
    entry_t            head;

    // Handshake and write-port selection. Ready is based on the registered
    // count only, so a full buffer never accepts even when it pops that cycle.
    // A result for x0 is accepted but dropped. Writeback to x0 is not a real
    // write, so it leaves the port free for the buffer.
    always_comb begin
        mdReady = rst_ni && (count_q < DEPTH_C);
        push    = md_valid_i && mdReady && (md_addr_i != '0);
        wbSel   = wb_we_i && (wb_addr_i != '0);
        pop     = !wbSel && (count_q != '0);
        head    = bufMem_q[rdPtr_q];
    end

    // Next-state for FIFO pointers/count and the registered write port.
    // Address/data hold their previous value when no write is selected.
    always_comb begin
        rdPtr_d   = rdPtr_q;
        wrPtr_d   = wrPtr_q;
        count_d   = count_q;
        rfWe_d    = 1'b0;
        rfWaddr_d = rfWaddr_q;
        rfWd_d    = rfWd_q;
        fromBuf_d = 1'b0;

        if (push) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        if (wbSel) begin
            rfWe_d    = 1'b1;
            rfWaddr_d = wb_addr_i;
            rfWd_d    = wb_data_i;
        end else if (pop) begin
            rfWe_d    = 1'b1;
            rfWaddr_d = head.addr;
            rfWd_d    = head.data;
            fromBuf_d = 1'b1;
        end
    end

    // Scoreboard. A bit clears on the same edge the register file captures
    // the buffered result, so a reader never sees pend=0 with stale data.
    // A new issue to the same register on that edge must win the race.
    always_comb begin
        pendMask_d = pendMask_q;
        if (rfWe_q && fromBuf_q) begin
            pendMask_d[rfWaddr_q] = 1'b0;
        end
        if (iss_valid_i && (iss_rd_i != '0)) begin
            pendMask_d[iss_rd_i] = 1'b1;
        end
        pendMask_d[0] = 1'b0;
    end

    // State registers; reset discards buffered results and any in-flight write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                bufMem_q[i] <= '0;
            end
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            rfWe_q     <= 1'b0;
            rfWaddr_q  <= '0;
            rfWd_q     <= '0;
            fromBuf_q  <= 1'b0;
            pendMask_q <= '0;
        end else begin
            if (push) begin
                bufMem_q[wrPtr_q] <= '{addr: md_addr_i, data: md_data_i};
            end
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            rfWe_q     <= rfWe_d;
            rfWaddr_q  <= rfWaddr_d;
            rfWd_q     <= rfWd_d;
            fromBuf_q  <= fromBuf_d;
            pendMask_q <= pendMask_d;
        end
    end

    assign md_ready_o  = mdReady;
    assign rs1_pend_o  = (rs1_addr_i != '0) && pendMask_q[rs1_addr_i];
    assign rs2_pend_o  = (rs2_addr_i != '0) && pendMask_q[rs2_addr_i];
    assign pend_mask_o = pendMask_q;
    assign rf_we_o     = rfWe_q;
    assign rf_waddr_o  = rfWaddr_q;
    assign rf_wd_o     = rfWd_q;
    assign buf_count_o = count_q;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wport_arbiter
//
// Directed table of cycles with hand-derived expectations, then randomized
// traffic checked against a queue-based reference model, plus reset cases.
// -----------------------------------------------------------------------------
module tb_rf_wport_arbiter;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        wbWe;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        mdValid;
    logic [4:0]  mdAddr;
    logic [31:0] mdData;
    logic        mdReady;
    logic        issValid;
    logic [4:0]  issRd;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic        rs1Pend;
    logic        rs2Pend;
    logic [31:0] pendMask;
    logic        rfWe;
    logic [4:0]  rfWaddr;
    logic [31:0] rfWd;
    logic [1:0]  bufCount;

    int vectors     = 0;
    int miscompares = 0;

    rf_wport_arbiter #(.XLEN(32), .AW(5), .BUF_DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wb_we_i     (wbWe),
        .wb_addr_i   (wbAddr),
        .wb_data_i   (wbData),
        .md_valid_i  (mdValid),
        .md_addr_i   (mdAddr),
        .md_data_i   (mdData),
        .md_ready_o  (mdReady),
        .iss_valid_i (issValid),
        .iss_rd_i    (issRd),
        .rs1_addr_i  (rs1Addr),
        .rs2_addr_i  (rs2Addr),
        .rs1_pend_o  (rs1Pend),
        .rs2_pend_o  (rs2Pend),
        .pend_mask_o (pendMask),
        .rf_we_o     (rfWe),
        .rf_waddr_o  (rfWaddr),
        .rf_wd_o     (rfWd),
        .buf_count_o (bufCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wbWe;
        logic [4:0]  wbAddr;
        logic [31:0] wbData;
        logic        mdValid;
        logic [4:0]  mdAddr;
        logic [31:0] mdData;
        logic        issValid;
        logic [4:0]  issRd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        expReady;
        logic        expRs1Pend;
        logic        expRs2Pend;
        logic        expRfWe;
        logic [4:0]  expRfAddr;
        logic [31:0] expRfWd;
        logic [31:0] expPend;
        logic [1:0]  expCount;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } res_t;

    // Reference model: the buffer is a plain queue, the scoreboard a bit
    // vector, and the write port is what the model decided last cycle.
    res_t        mQ[$];
    logic [31:0] mPend;
    logic        mRfWe;
    logic [4:0]  mRfAddr;
    logic [31:0] mRfWd;
    logic        mFromBuf;
    logic        mReady;
    logic        mRs1Pend;
    logic        mRs2Pend;

    // Sampled DUT values just before the active edge.
    logic        preReady;
    logic        preRs1;
    logic        preRs2;

    function automatic void modelReset();
        mQ.delete();
        mPend    = '0;
        mRfWe    = 1'b0;
        mRfAddr  = '0;
        mRfWd    = '0;
        mFromBuf = 1'b0;
    endfunction

    function automatic void modelComb();
        mReady   = (mQ.size() < DEPTH);
        mRs1Pend = (rs1Addr != 0) && mPend[rs1Addr];
        mRs2Pend = (rs2Addr != 0) && mPend[rs2Addr];
    endfunction

    function automatic void modelStep();
        logic        accepted;
        logic        pipeWrite;
        logic [31:0] nextPend;
        res_t        r;
        accepted  = mdValid && (mQ.size() < DEPTH);
        pipeWrite = wbWe && (wbAddr != 0);
        nextPend  = mPend;
        if (mRfWe && mFromBuf) nextPend[mRfAddr] = 1'b0;
        if (issValid && issRd != 0) nextPend[issRd] = 1'b1;
        if (pipeWrite) begin
            mRfWe = 1'b1; mRfAddr = wbAddr; mRfWd = wbData; mFromBuf = 1'b0;
        end else if (mQ.size() > 0) begin
            r = mQ.pop_front();
            mRfWe = 1'b1; mRfAddr = r.addr; mRfWd = r.data; mFromBuf = 1'b1;
        end else begin
            mRfWe = 1'b0; mFromBuf = 1'b0;
        end
        if (accepted && mdAddr != 0) begin
            r.addr = mdAddr;
            r.data = mdData;
            mQ.push_back(r);
        end
        mPend = nextPend;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs just after a rising edge, samples the
    // combinational outputs on the falling edge, advances the model and
    // returns 1 time unit after the next rising edge.
    task automatic applyStimulus(input vec_t v);
        wbWe = v.wbWe; wbAddr = v.wbAddr; wbData = v.wbData;
        mdValid = v.mdValid; mdAddr = v.mdAddr; mdData = v.mdData;
        issValid = v.issValid; issRd = v.issRd;
        rs1Addr = v.rs1; rs2Addr = v.rs2;
        @(negedge clk);
        preReady = mdReady;
        preRs1   = rs1Pend;
        preRs2   = rs2Pend;
        modelComb();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t idleVec();
        vec_t v;
        v = '{0,0,0, 0,0,0, 0,0, 0,0, 1,0,0, 0,0,0, 0,0};
        return v;
    endfunction

    // Hand-derived directed cycles, starting from an empty, freshly reset state.
    vec_t table_q[$];

    initial begin
        // pipeline write
        table_q.push_back('{1,5,32'hDEADBEEF, 0,0,0, 0,0, 0,0, 1,0,0, 1,5,32'hDEADBEEF, 32'h0, 0});
        // scoreboard round trip on x7
        table_q.push_back('{0,0,0, 0,0,0, 1,7, 7,0, 1,0,0, 0,0,0, 32'h80, 0});
        table_q.push_back('{0,0,0, 0,0,0, 0,0, 7,0, 1,1,0, 0,0,0, 32'h80, 0});
        table_q.push_back('{0,0,0, 1,7,32'h12345678, 0,0, 7,0, 1,1,0, 0,0,0, 32'h80, 1});
        table_q.push_back('{0,0,0, 0,0,0, 0,0, 7,0, 1,1,0, 1,7,32'h12345678, 32'h80, 0});
        table_q.push_back('{0,0,0, 0,0,0, 0,0, 7,0, 1,1,0, 0,0,0, 32'h0, 0});
        table_q.push_back('{0,0,0, 0,0,0, 0,0, 7,0, 1,0,0, 0,0,0, 32'h0, 0});
        // conflict: four pipeline writes to x9 hold off the buffered x3
        table_q.push_back('{1,9,32'h100, 1,3,32'hA, 0,0, 0,0, 1,0,0, 1,9,32'h100, 32'h0, 1});
        table_q.push_back('{1,9,32'h101, 0,0,0, 0,0, 0,0, 1,0,0, 1,9,32'h101, 32'h0, 1});
        table_q.push_back('{1,9,32'h102, 0,0,0, 0,0, 0,0, 1,0,0, 1,9,32'h102, 32'h0, 1});
        table_q.push_back('{1,9,32'h103, 0,0,0, 0,0, 0,0, 1,0,0, 1,9,32'h103, 32'h0, 1});
        table_q.push_back('{0,0,0, 0,0,0, 0,0, 0,0, 1,0,0, 1,3,32'hA, 32'h0, 0});
        table_q.push_back('{0,0,0, 0,0,0, 0,0, 0,0, 1,0,0, 0,0,0, 32'h0, 0});
        // full buffer: third result waits for a pop
        table_q.push_back('{1,9,32'h200, 1,10,32'hB0, 0,0, 0,0, 1,0,0, 1,9,32'h200, 32'h0, 1});
        table_q.push_back('{1,9,32'h201, 1,11,32'hB1, 0,0, 0,0, 1,0,0, 1,9,32'h201, 32'h0, 2});
        table_q.push_back('{1,9,32'h202, 1,12,32'hB2, 0,0, 0,0, 0,0,0, 1,9,32'h202, 32'h0, 2});
        table_q.push_back('{0,0,0, 1,12,32'hB2, 0,0, 0,0, 0,0,0, 1,10,32'hB0, 32'h0, 1});
        table_q.push_back('{0,0,0, 1,12,32'hB2, 0,0, 0,0, 1,0,0, 1,11,32'hB1, 32'h0, 1});
        table_q.push_back('{0,0,0, 0,0,0, 0,0, 0,0, 1,0,0, 1,12,32'hB2, 32'h0, 0});
        table_q.push_back('{0,0,0, 0,0,0, 0,0, 0,0, 1,0,0, 0,0,0, 32'h0, 0});
        // set wins over clear on x4
        table_q.push_back('{0,0,0, 0,0,0, 1,4, 0,0, 1,0,0, 0,0,0, 32'h10, 0});
        table_q.push_back('{0,0,0, 1,4,32'h44, 0,0, 0,0, 1,0,0, 0,0,0, 32'h10, 1});
        table_q.push_back('{0,0,0, 0,0,0, 0,0, 0,0, 1,0,0, 1,4,32'h44, 32'h10, 0});
        table_q.push_back('{0,0,0, 0,0,0, 1,4, 4,0, 1,1,0, 0,0,0, 32'h10, 0});
        table_q.push_back('{0,0,0, 0,0,0, 0,0, 4,4, 1,1,1, 0,0,0, 32'h10, 0});
        // result for x0 is swallowed
        table_q.push_back('{0,0,0, 1,0,32'hFF, 0,0, 0,4, 1,0,1, 0,0,0, 32'h10, 0});
        table_q.push_back('{0,0,0, 0,0,0, 0,0, 0,4, 1,0,1, 0,0,0, 32'h10, 0});
        // writeback to x0 lets the buffer drain
        table_q.push_back('{0,0,0, 1,5,32'h55, 0,0, 0,0, 1,0,0, 0,0,0, 32'h10, 1});
        table_q.push_back('{1,0,32'h999, 0,0,0, 0,0, 0,0, 1,0,0, 1,5,32'h55, 32'h10, 0});
        table_q.push_back('{0,0,0, 0,0,0, 0,0, 0,0, 1,0,0, 0,0,0, 32'h10, 0});
    end

    initial begin
        vec_t v;

        // Reset held with active requests on the inputs.
        rst_n = 1'b0;
        wbWe = 1'b1; wbAddr = 5'd5; wbData = 32'h1111;
        mdValid = 1'b1; mdAddr = 5'd6; mdData = 32'h2222;
        issValid = 1'b1; issRd = 5'd6;
        rs1Addr = 5'd6; rs2Addr = 5'd0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rf_we",    32'(rfWe),     32'h0);
        checkOutput("reset_rf_waddr", 32'(rfWaddr),  32'h0);
        checkOutput("reset_rf_wd",    rfWd,          32'h0);
        checkOutput("reset_md_ready", 32'(mdReady),  32'h0);
        checkOutput("reset_pend",     pendMask,      32'h0);
        checkOutput("reset_count",    32'(bufCount), 32'h0);
        @(negedge clk);
        v = idleVec();
        wbWe = v.wbWe; mdValid = v.mdValid; issValid = v.issValid;
        rs1Addr = v.rs1; rs2Addr = v.rs2;
        rst_n = 1'b1;
        #1;
        checkOutput("release_md_ready", 32'(mdReady),  32'h1);
        checkOutput("release_count",    32'(bufCount), 32'h0);
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < table_q.size(); i++) begin
            applyStimulus(table_q[i]);
            checkOutput($sformatf("tbl%0d_md_ready", i), 32'(preReady), 32'(table_q[i].expReady));
            checkOutput($sformatf("tbl%0d_rs1_pend", i), 32'(preRs1),   32'(table_q[i].expRs1Pend));
            checkOutput($sformatf("tbl%0d_rs2_pend", i), 32'(preRs2),   32'(table_q[i].expRs2Pend));
            checkOutput($sformatf("tbl%0d_rf_we", i),    32'(rfWe),     32'(table_q[i].expRfWe));
            if (table_q[i].expRfWe) begin
                checkOutput($sformatf("tbl%0d_rf_waddr", i), 32'(rfWaddr), 32'(table_q[i].expRfAddr));
                checkOutput($sformatf("tbl%0d_rf_wd", i),    rfWd,         table_q[i].expRfWd);
            end
            checkOutput($sformatf("tbl%0d_pend", i),  pendMask,      table_q[i].expPend);
            checkOutput($sformatf("tbl%0d_count", i), 32'(bufCount), 32'(table_q[i].expCount));
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            v = idleVec();
            v.wbWe     = ($urandom_range(0, 99) < 55);
            v.wbAddr   = 5'($urandom_range(0, 31));
            v.wbData   = $urandom;
            v.mdValid  = ($urandom_range(0, 99) < 60);
            v.mdAddr   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            v.mdData   = $urandom;
            v.issValid = ($urandom_range(0, 99) < 30);
            v.issRd    = 5'($urandom_range(0, 31));
            v.rs1      = 5'($urandom_range(0, 31));
            v.rs2      = 5'($urandom_range(0, 31));
            applyStimulus(v);
            checkOutput("rnd_md_ready", 32'(preReady), 32'(mReady));
            checkOutput("rnd_rs1_pend", 32'(preRs1),   32'(mRs1Pend));
            checkOutput("rnd_rs2_pend", 32'(preRs2),   32'(mRs2Pend));
            checkOutput("rnd_rf_we",    32'(rfWe),     32'(mRfWe));
            if (mRfWe) begin
                checkOutput("rnd_rf_waddr", 32'(rfWaddr), 32'(mRfAddr));
                checkOutput("rnd_rf_wd",    rfWd,         mRfWd);
            end
            checkOutput("rnd_pend",  pendMask,      mPend);
            checkOutput("rnd_count", 32'(bufCount), 32'(mQ.size()));
        end

        // Reset mid-operation: buffer holds a result, a write is in flight.
        v = idleVec();
        v.wbWe = 1'b1; v.wbAddr = 5'd9; v.wbData = 32'h77;
        v.mdValid = 1'b1; v.mdAddr = 5'd13; v.mdData = 32'h88;
        v.issValid = 1'b1; v.issRd = 5'd13;
        applyStimulus(v);
        checkOutput("midrst_pre_rf_we", 32'(rfWe), 32'h1);
        checkOutput("midrst_pre_pend13", 32'(pendMask[13]), 32'h1);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midrst_rf_we",    32'(rfWe),     32'h0);
        checkOutput("midrst_count",    32'(bufCount), 32'h0);
        checkOutput("midrst_pend",     pendMask,      32'h0);
        checkOutput("midrst_md_ready", 32'(mdReady),  32'h0);
        @(negedge clk);
        wbWe = 1'b0; mdValid = 1'b0; issValid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postrst_rf_we",    32'(rfWe),     32'h0);
        checkOutput("postrst_md_ready", 32'(mdReady),  32'h1);
        checkOutput("postrst_count",    32'(bufCount), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Shares the single write port of the 32x32 register file between the in-order pipeline writeback and the multi-cycle MUL/DIV unit, and keeps a scoreboard of destination registers still owed a MUL/DIV result. It sits between the WB stage / MUL-DIV unit and the register file. It exports per-source-operand pending flags so the ID-stage hazard logic can stall readers of registers whose value has not yet been written.

## Interface
- XLEN, 32, data width
- AW, 5, register address width (2^AW registers)
- BUF_DEPTH, 2, MUL/DIV result buffer entries (power of two, >=2)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- wb_we  in  1  pipeline writeback valid (cannot be stalled)
- wb_addr  in  AW  pipeline destination
- wb_data  in  XLEN  pipeline result
- md_valid  in  1  MUL/DIV result valid
- md_addr  in  AW  MUL/DIV destination
- md_data  in  XLEN  MUL/DIV result
- md_ready  out  1  buffer can accept a result
- iss_valid  in  1  MUL/DIV instruction issued this cycle
- iss_rd  in  AW  its destination
- rs1_addr, rs2_addr  in  AW  ID-stage source addresses
- rs1_pend, rs2_pend  out  1  source awaiting a MUL/DIV write (combinational)
- pend_mask  out  2^AW  scoreboard bits, bit 0 always 0
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  AW  write address (registered)
- rf_wd  out  XLEN  write data (registered)
- buf_count  out  clog2(BUF_DEPTH)+1  buffer occupancy

## Operation
- MUL/DIV results enter a BUF_DEPTH FIFO; handshake completes when md_valid && md_ready. md_ready = (buf_count < BUF_DEPTH), forced 0 while rst low.
- Accepted result with md_addr==0: consumed, not pushed, no write, no scoreboard change.
- Per-cycle write select, priority order:
  - wb_we && wb_addr!=0: pipeline write.
  - else buffer non-empty: pop head, write it.
  - else no write (rf_we=0 next cycle).
- wb_we with wb_addr==0: treated as no pipeline write; buffer may drain that cycle.
- Push and pop in the same cycle are both allowed; count unchanged. Push is never allowed when full, even if a pop occurs that cycle.
- Scoreboard:
  - iss_valid && iss_rd!=0 sets pend_mask[iss_rd].
  - Bit for rf_waddr clears on the edge where rf_we==1 and the registered write came from the buffer. An internal source flag is registered alongside rf_*.
  - Set and clear of the same bit in the same cycle: set wins.
  - Pipeline writes never touch the scoreboard.
- rsN_pend = pend_mask[rsN_addr] when rsN_addr!=0, else 0.
- Pipeline writes always win. Continuous wb_we starves the buffer; backpressure reaches the MUL/DIV unit via md_ready. No fairness guarantee.

## Timing
- Reset (rst low, async): rf_we=0, rf_waddr=0, rf_wd=0, pend_mask=0, buffer empty, buf_count=0, md_ready=0. md_ready rises combinationally once rst deasserts.
- Pipeline write latency: wb_* sampled at edge T, rf_* valid after T, register file captures at T+1.
- MUL/DIV latency (empty buffer, no wb conflict):
  - accept at edge T, pop selected in cycle after T.
  - rf_* valid after T+1, regfile and scoreboard update at T+2.
- pend bit is clear in the same cycle the new value is readable from the register file. No window where rsN_pend=0 with stale data.
- Reset mid-operation: buffered results discarded, scoreboard cleared, any in-flight rf_we dropped.

## Test plan
- Reset: hold rst=0 with md_valid=1, wb_we=1 -> rf_we=0, md_ready=0, pend_mask=0. Release -> md_ready=1, buf_count=0.
- Pipeline only: wb_we=1, wb_addr=5, wb_data=0xDEADBEEF at edge T -> rf_we=1, rf_waddr=5, rf_wd=0xDEADBEEF after T. pend_mask unchanged.
- Scoreboard round trip:
  - iss_valid, iss_rd=7 -> pend_mask[7]=1, rs1_pend=1 for rs1_addr=7.
  - Then md result (7, 0x12345678) -> written at T+2, pend_mask[7]=0 on the same edge.
  - rs1_addr=0 -> rs1_pend=0 always.
- Conflict: md result (3, 0xA) accepted while wb_we held 4 cycles (addr 9) -> four pipeline writes to 9 first, then write of 3=0xA. buf_count=1 throughout the stall.
- Full buffer: hold wb_we=1, offer 3 md results -> first two accepted, md_ready=0 with buf_count=2. Third accepted only after wb_we drops and one pop occurs.
- Corner cases:
  - iss_rd=4 issued on the edge that clears bit 4 -> pend_mask[4] stays 1.
  - md_addr=0 accepted -> no rf_we, buf_count unchanged.
